// File: rtl/nrz_deser_pkg.sv
// Shared types and helpers for the NRZ frame deserializer.
// State encoding, parity modes and the expected-parity calculation.
package nrz_deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Parity bit the sender must transmit, given the XOR of the data bits.
    function automatic logic expParity(input logic dataXor, input int mode);
        return (mode == PAR_ODD) ? ~dataXor : dataXor;
    endfunction

endpackage

// File: rtl/nrz_word_holding_reg.sv
// One-deep valid/ready holding register for received words.
// A word arriving while the register is full and not being drained is dropped and flagged.
module nrz_word_holding_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;

    // A load wins over a same-cycle accept so valid stays high with the new word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_load && (!r_valid || i_ready)) begin
                r_data  <= i_data;
                r_valid <= 1'b1;
            end else begin
                if (i_load) begin
                    r_overrun <= 1'b1;
                end
                if (r_valid && i_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/nrz_frame_deserializer.sv
// Assembles start/data/parity/stop frames from the biphase decoder's bit strobes.
// Frame errors are reported as registered single-cycle pulses.
module nrz_frame_deserializer
    import nrz_deser_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int BIT_TIMEOUT = 2400
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 upstream_error,
    output logic [DATA_BITS-1:0] word_out,
    output logic                 word_valid,
    input  logic                 word_ready,
    output logic                 stop_error,
    output logic                 parity_error,
    output logic                 abort,
    output logic                 overrun
);

    localparam int CW = $clog2(DATA_BITS + 1);
    localparam int TW = $clog2(BIT_TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_BIT    = CW'(DATA_BITS - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(BIT_TIMEOUT);
    localparam logic [TW-1:0] LAST_TICK   = TW'(BIT_TIMEOUT - 1);

    state_t               r_state;
    logic [CW-1:0]        r_bitCnt;
    logic [TW-1:0]        r_timeout;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parAcc;
    logic                 r_parFail;
    logic                 r_stopErr;
    logic                 r_parErr;
    logic                 r_abort;

    logic w_bit;
    logic w_timeoutHit;
    logic w_abort;
    logic w_load;

    // upstream_error outranks a coincident bit strobe, which is then discarded.
    assign w_bit        = bit_valid && !upstream_error;
    assign w_timeoutHit = (r_state != ST_IDLE) && !bit_valid && (r_timeout == LAST_TICK);
    assign w_abort      = (r_state != ST_IDLE) && (upstream_error || w_timeoutHit);
    assign w_load       = (r_state == ST_STOP) && w_bit && bit_in && !r_parFail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_bitCnt  <= '0;
            r_timeout <= '0;
            r_shift   <= '0;
            r_parAcc  <= 1'b0;
            r_parFail <= 1'b0;
            r_stopErr <= 1'b0;
            r_parErr  <= 1'b0;
            r_abort   <= 1'b0;
        end else begin
            r_stopErr <= 1'b0;
            r_parErr  <= 1'b0;
            r_abort   <= 1'b0;

            if (r_state == ST_IDLE || bit_valid) begin
                r_timeout <= '0;
            end else if (r_timeout != TIMEOUT_MAX) begin
                r_timeout <= r_timeout + TW'(1);
            end

            if (w_abort) begin
                r_abort   <= 1'b1;
                r_state   <= ST_IDLE;
                r_timeout <= '0;
            end else if (w_bit) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!bit_in) begin
                            r_state   <= ST_DATA;
                            r_bitCnt  <= '0;
                            r_parAcc  <= 1'b0;
                            r_parFail <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        for (int i = 0; i < DATA_BITS; i++) begin
                            if (r_bitCnt == CW'(i)) begin
                                r_shift[i] <= bit_in;
                            end
                        end
                        r_parAcc <= r_parAcc ^ bit_in;
                        r_bitCnt <= r_bitCnt + CW'(1);
                        if (r_bitCnt == LAST_BIT) begin
                            r_state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end
                    end
                    ST_PARITY: begin
                        if (bit_in != expParity(r_parAcc, PARITY)) begin
                            r_parErr  <= 1'b1;
                            r_parFail <= 1'b1;
                        end
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        // A low stop bit is only an error; it never starts a new frame.
                        if (!bit_in) begin
                            r_stopErr <= 1'b1;
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    nrz_word_holding_reg #(
        .WIDTH(DATA_BITS)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_data    (r_shift),
        .i_ready   (word_ready),
        .o_data    (word_out),
        .o_valid   (word_valid),
        .o_overrun (overrun)
    );

    assign stop_error   = r_stopErr;
    assign parity_error = r_parErr;
    assign abort        = r_abort;

endmodule

// File: tb/tb_nrz_frame_deserializer.sv
// Scoreboard bench: instance 0 has no parity, instance 1 uses odd parity; both time out after 50 clocks.
// Expected words are queued as frames are sent and compared when the consumer accepts them.
module tb_nrz_frame_deserializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] bitValid  = 2'b00;
    logic [1:0] bitIn     = 2'b11;
    logic [1:0] upErr     = 2'b00;
    logic [1:0] wordReady = 2'b00;

    logic [7:0] wordOut [2];
    logic       wordValid [2];
    logic       stopError [2];
    logic       parityError [2];
    logic       abortP [2];
    logic       overrun [2];

    int checks = 0;
    int errors = 0;
    int stopCnt [2];
    int parCnt [2];
    int abortCnt [2];
    int ovrCnt [2];
    logic [7:0] expQ0 [$];
    logic [7:0] expQ1 [$];
    logic [7:0] expWord;
    int queueSize;

    always #5 clk = ~clk;

    nrz_frame_deserializer #(
        .DATA_BITS(8), .PARITY(0), .BIT_TIMEOUT(50)
    ) dutA (
        .clk(clk), .rst(rst), .bit_valid(bitValid[0]), .bit_in(bitIn[0]),
        .upstream_error(upErr[0]), .word_out(wordOut[0]), .word_valid(wordValid[0]),
        .word_ready(wordReady[0]), .stop_error(stopError[0]), .parity_error(parityError[0]),
        .abort(abortP[0]), .overrun(overrun[0])
    );

    nrz_frame_deserializer #(
        .DATA_BITS(8), .PARITY(2), .BIT_TIMEOUT(50)
    ) dutB (
        .clk(clk), .rst(rst), .bit_valid(bitValid[1]), .bit_in(bitIn[1]),
        .upstream_error(upErr[1]), .word_out(wordOut[1]), .word_valid(wordValid[1]),
        .word_ready(wordReady[1]), .stop_error(stopError[1]), .parity_error(parityError[1]),
        .abort(abortP[1]), .overrun(overrun[1])
    );

    // Consumer side: count pulses and pop the scoreboard on every accepted word.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (stopError[d])   stopCnt[d]++;
            if (parityError[d]) parCnt[d]++;
            if (abortP[d])      abortCnt[d]++;
            if (overrun[d])     ovrCnt[d]++;
            if (wordValid[d] && wordReady[d]) begin
                checks++;
                queueSize = (d == 0) ? expQ0.size() : expQ1.size();
                if (queueSize == 0) begin
                    errors++;
                    $display("[TB] FAIL accept_unexpected dut%0d: got %h expected no word", d, wordOut[d]);
                end else begin
                    expWord = (d == 0) ? expQ0.pop_front() : expQ1.pop_front();
                    if (wordOut[d] !== expWord) begin
                        errors++;
                        $display("[TB] FAIL accept_word dut%0d: got %h expected %h", d, wordOut[d], expWord);
                    end
                end
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sendBit(input int d, input logic b);
        bitValid[d] = 1'b1;
        bitIn[d]    = b;
        stepCycle();
        bitValid[d] = 1'b0;
        bitIn[d]    = 1'b1;
    endtask

    task automatic sendStartData(input int d, input logic [7:0] w);
        sendBit(d, 1'b0);
        for (int i = 0; i < 8; i++) sendBit(d, w[i]);
    endtask

    task automatic sendFrame(input int d, input logic [7:0] w, input int parMode,
                             input bit badParity, input logic stopBit, input bit expectWord);
        logic p;
        if (expectWord) begin
            if (d == 0) expQ0.push_back(w);
            else        expQ1.push_back(w);
        end
        sendStartData(d, w);
        if (parMode != 0) begin
            p = (parMode == 2) ? ~(^w) : ^w;
            if (badParity) p = ~p;
            sendBit(d, p);
        end
        sendBit(d, stopBit);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) stepCycle();
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({wordOut[d], wordValid[d], stopError[d], parityError[d], abortP[d], overrun[d]} !== 13'h0) begin
                errors++;
                $display("[TB] FAIL reset_outputs dut%0d: got %h expected 0", d,
                         {wordOut[d], wordValid[d], stopError[d], parityError[d], abortP[d], overrun[d]});
            end
        end
        rst = 1'b0;
        stepCycle();
    endtask

    task automatic test_basic();
        int s0, p0, a0, o0;
        s0 = stopCnt[0]; p0 = parCnt[0]; a0 = abortCnt[0]; o0 = ovrCnt[0];
        wordReady[0] = 1'b1;
        sendFrame(0, 8'h5A, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (wordValid[0] !== 1'b1 || wordOut[0] !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL basic_latency: got valid=%b word=%h expected valid=1 word=5a", wordValid[0], wordOut[0]);
        end
        stepCycle();
        checks++;
        if (wordValid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_valid_fall: got %b expected 0", wordValid[0]);
        end
        checks++;
        if (stopCnt[0] != s0 || parCnt[0] != p0 || abortCnt[0] != a0 || ovrCnt[0] != o0) begin
            errors++;
            $display("[TB] FAIL basic_no_errors: got pulses s=%0d p=%0d a=%0d o=%0d expected 0",
                     stopCnt[0] - s0, parCnt[0] - p0, abortCnt[0] - a0, ovrCnt[0] - o0);
        end
    endtask

    task automatic test_parity();
        wordReady[1] = 1'b1;
        sendStartData(1, 8'h03);
        sendBit(1, 1'b0);
        checks++;
        if (parityError[1] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL parity_pulse: got %b expected 1", parityError[1]);
        end
        sendBit(1, 1'b1);
        checks++;
        if (wordValid[1] !== 1'b0 || parityError[1] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL parity_discard: got valid=%b perr=%b expected 0 0", wordValid[1], parityError[1]);
        end
        sendFrame(1, 8'h03, 2, 1'b0, 1'b1, 1'b1);
        checks++;
        if (wordValid[1] !== 1'b1 || wordOut[1] !== 8'h03) begin
            errors++;
            $display("[TB] FAIL parity_good: got valid=%b word=%h expected 1 03", wordValid[1], wordOut[1]);
        end
        stepCycle();
    endtask

    task automatic test_stop_error();
        wordReady[0] = 1'b1;
        sendFrame(0, 8'h3C, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (stopError[0] !== 1'b1 || wordValid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_pulse: got serr=%b valid=%b expected 1 0", stopError[0], wordValid[0]);
        end
        stepCycle();
        checks++;
        if (stopError[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stop_width: got %b expected 0", stopError[0]);
        end
        sendFrame(0, 8'hA5, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (wordValid[0] !== 1'b1 || wordOut[0] !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL stop_recover: got valid=%b word=%h expected 1 a5", wordValid[0], wordOut[0]);
        end
        stepCycle();
    endtask

    task automatic test_overrun();
        wordReady[0] = 1'b0;
        sendFrame(0, 8'h11, 0, 1'b0, 1'b1, 1'b1);
        sendFrame(0, 8'h22, 0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (overrun[0] !== 1'b1 || wordOut[0] !== 8'h11 || wordValid[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_pulse: got ovr=%b word=%h valid=%b expected 1 11 1",
                     overrun[0], wordOut[0], wordValid[0]);
        end
        wordReady[0] = 1'b1;
        stepCycle();
        checks++;
        if (wordValid[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_drain: got %b expected 0", wordValid[0]);
        end
    endtask

    task automatic test_back_to_back();
        wordReady[0] = 1'b0;
        sendFrame(0, 8'h33, 0, 1'b0, 1'b1, 1'b1);
        expQ0.push_back(8'h44);
        sendStartData(0, 8'h44);
        wordReady[0] = 1'b1;
        sendBit(0, 1'b1);
        checks++;
        if (wordValid[0] !== 1'b1 || wordOut[0] !== 8'h44 || overrun[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL swap_load: got valid=%b word=%h ovr=%b expected 1 44 0",
                     wordValid[0], wordOut[0], overrun[0]);
        end
        stepCycle();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        sendBit(0, 1'b0);
        sendBit(0, 1'b1);
        sendBit(0, 1'b0);
        sendBit(0, 1'b1);
        for (int i = 1; i < 50; i++) begin
            stepCycle();
            if (abortP[0] !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("[TB] FAIL timeout_early: got %0d early cycles expected 0", early);
        end
        stepCycle();
        checks++;
        if (abortP[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_abort: got %b expected 1", abortP[0]);
        end
        stepCycle();
        checks++;
        if (abortP[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_width: got %b expected 0", abortP[0]);
        end
    endtask

    task automatic test_upstream();
        wordReady[0] = 1'b1;
        sendBit(0, 1'b0);
        for (int i = 0; i < 4; i++) sendBit(0, 1'b1);
        upErr[0] = 1'b1;
        stepCycle();
        upErr[0] = 1'b0;
        checks++;
        if (abortP[0] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL upstream_abort: got %b expected 1", abortP[0]);
        end
        stepCycle();
        upErr[0] = 1'b1;
        stepCycle();
        upErr[0] = 1'b0;
        checks++;
        if (abortP[0] !== 1'b0) begin
            errors++;
            $display("[TB] FAIL upstream_idle: got %b expected 0", abortP[0]);
        end
        sendFrame(0, 8'hC3, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (wordValid[0] !== 1'b1 || wordOut[0] !== 8'hC3) begin
            errors++;
            $display("[TB] FAIL upstream_recover: got valid=%b word=%h expected 1 c3", wordValid[0], wordOut[0]);
        end
        stepCycle();
    endtask

    task automatic test_reset_midframe();
        wordReady[0] = 1'b0;
        sendFrame(0, 8'h77, 0, 1'b0, 1'b1, 1'b0);
        sendBit(0, 1'b0);
        sendBit(0, 1'b1);
        sendBit(0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({wordOut[0], wordValid[0], stopError[0], parityError[0], abortP[0], overrun[0]} !== 13'h0) begin
            errors++;
            $display("[TB] FAIL reset_async: got %h expected 0",
                     {wordOut[0], wordValid[0], stopError[0], parityError[0], abortP[0], overrun[0]});
        end
        stepCycle();
        rst = 1'b0;
        stepCycle();
        wordReady[0] = 1'b1;
        sendFrame(0, 8'hFF, 0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (wordValid[0] !== 1'b1 || wordOut[0] !== 8'hFF) begin
            errors++;
            $display("[TB] FAIL reset_recover: got valid=%b word=%h expected 1 ff", wordValid[0], wordOut[0]);
        end
        stepCycle();
        stepCycle();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            stopCnt[d] = 0; parCnt[d] = 0; abortCnt[d] = 0; ovrCnt[d] = 0;
        end
        test_reset();
        test_basic();
        test_parity();
        test_stop_error();
        test_overrun();
        test_back_to_back();
        test_timeout();
        test_upstream();
        test_reset_midframe();
        checks++;
        if (expQ0.size() != 0 || expQ1.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d/%0d pending expected 0/0", expQ0.size(), expQ1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nrz_frame_deserializer.md
# nrz_frame_deserializer

- Sits directly downstream of the biphase-to-NRZ decoder.
- Consumes its per-bit strobe, NRZ data and framing-error pulse, and assembles asynchronous-style frames: start bit 0, DATA_BITS bits LSB first, optional parity, stop bit 1.
- Completed words are presented in a one-deep holding register with a valid/ready handshake.
- Frame-level errors (bad stop, parity mismatch, mid-frame timeout, upstream framing error, overrun) are reported as single-cycle pulses.

## Interface
- DATA_BITS, 8, data bits per frame (1..16)
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- BIT_TIMEOUT, 2400, max clocks between bit strobes inside a frame before abort

- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- bit_valid  input  1  one-cycle strobe: a decoded bit is present on bit_in
- bit_in  input  1  decoded NRZ bit, sampled only when bit_valid=1
- upstream_error  input  1  one-cycle framing-error pulse from the decoder
- word_out  output  DATA_BITS  received word, stable while word_valid=1
- word_valid  output  1  holding register full
- word_ready  input  1  consumer accepts word_out when word_valid&&word_ready
- stop_error  output  1  pulse: stop bit sampled as 0
- parity_error  output  1  pulse: parity mismatch
- abort  output  1  pulse: frame abandoned (timeout or upstream_error mid-frame)
- overrun  output  1  pulse: word completed while the holding register was full and not being accepted

## Operation
- States:
  - IDLE → START_SEEN on bit_valid && bit_in==0. bit_in==1 in IDLE is the marking line and is ignored.
  - DATA: shifts DATA_BITS bits, LSB first.
  - PARITY: entered only if PARITY≠0.
  - STOP.
  - Every state except IDLE returns to IDLE at end of frame or on abort.
- START_SEEN is folded into DATA: the first bit_valid after the start bit is data bit 0.
- Bit counter: $clog2(DATA_BITS+1) bits, cleared on entry to DATA. DATA→PARITY/STOP when the counter reaches DATA_BITS-1 and bit_valid=1.
- Parity accumulator: XOR of the data bits.
  - Even mode: the parity bit must make the total count of 1s even.
  - Odd mode: the total count of 1s must be odd.
  - On mismatch: pulse parity_error; the frame continues to STOP and the word is discarded.
- STOP handling:
  - bit_in==1 with no parity error: the word is delivered.
  - bit_in==0: pulse stop_error, discard the word, return to IDLE. The 0 is not treated as a new start bit.
- Delivery:
  - If word_valid==0, or word_ready==1 in the same cycle: load word_out and set word_valid.
  - Otherwise keep the old word, drop the new one, and pulse overrun.
- Timeout counter:
  - Cleared on every bit_valid; counts only outside IDLE; saturates at BIT_TIMEOUT.
  - Reaching BIT_TIMEOUT pulses abort and returns to IDLE.
- upstream_error outside IDLE pulses abort and returns to IDLE. In IDLE it is ignored.
- Same cycle as bit_valid: upstream_error wins and the bit is discarded.
- word_valid clears on word_valid&&word_ready unless a new word loads in the same cycle.

## Timing
- Reset (asynchronous assert): state=IDLE, counters=0, word_out=0, word_valid=0, all error pulses=0.
- rst during a frame discards the partial word. A word already held is lost.
- Latency: word_valid rises on the clock edge after the cycle carrying the stop-bit bit_valid.
- Error pulses are registered, exactly one cycle wide, and assert in the cycle after the triggering strobe or timeout edge.
- Back-to-back bit_valid on consecutive cycles is legal and must be handled at full rate.
- Accepting a word and loading a new one in the same cycle leaves word_valid=1 with the new data and no overrun.

## Structure
- Package nrz_deser_pkg holds:
  - state enum (IDLE, DATA, PARITY, STOP);
  - parity-mode localparams (PAR_NONE, PAR_EVEN, PAR_ODD);
  - a function computing the expected parity bit.
- Sub-module nrz_word_holding_reg: one-deep valid/ready register with overrun detect, parameterised on width.
- The FSM, bit counter and timeout counter live in the top module.

## Test plan
- DATA_BITS=8, PARITY=0: bits 0, 0,1,0,1,1,0,1,0, 1 with word_ready=1 → word_out=0x5A, word_valid for 1 cycle after the stop strobe, no error pulses.
- PARITY=2 (odd): send 0x03 with parity bit 0 → parity_error pulse, word_valid stays 0. Resend with parity 1 → word_out=0x03.
- Stop bit sent as 0 → stop_error pulse, FSM in IDLE. A following valid frame 0xA5 is received correctly.
- word_ready=0, two frames 0x11 then 0x22 → word_out stays 0x11, overrun pulse on the second completion. Raise word_ready → 0x11 accepted, word_valid falls.
- BIT_TIMEOUT=50: start bit plus 3 data bits, then silence → abort exactly 50 clocks after the last strobe. upstream_error after 4 data bits → abort next cycle.
- Assert rst mid-frame and while word_valid=1 → all outputs 0 immediately. The next full frame 0xFF is received.
